// File: rtl/display_reg_bank.sv
// Host-port register bank: host writes land in a shadow bank and a commit copies
// shadow->active on the next frame_start. Optional frame watchdog: DISP_REG_WATCHDOG_EN.
module display_reg_bank #(
   parameter  int DATA_W         = 8,
   parameter  int NUM_REGS       = 8,
   parameter  int TIMEOUT_FRAMES = 60,
   localparam int ADDR_W         = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
   input  logic                       Clk,
   input  logic                       Reset_n,
   input  logic [ADDR_W-1:0]          addr,
   input  logic [DATA_W-1:0]          data_in,
   input  logic                       write,
   input  logic                       commit,
   input  logic                       frame_start,
   output logic [NUM_REGS*DATA_W-1:0] regs_active,
   output logic                       status,
   output logic                       updated,
   output logic                       addr_err,
   output logic                       stale
);

   typedef enum logic {IDLE, ARMED} state_t;

   state_t            state;
   logic [DATA_W-1:0] shadow [NUM_REGS];
   logic [DATA_W-1:0] active [NUM_REGS];
   logic              addr_ok;
   logic              copy;

   // With a power-of-two bank every encodable address is a real register.
   if (NUM_REGS == (1 << ADDR_W)) begin : g_addr_full
      assign addr_ok = 1'b1;
   end else begin : g_addr_part
      assign addr_ok = ({1'b0, addr} < (ADDR_W+1)'(NUM_REGS));
   end

   assign copy = (state == ARMED) && frame_start;

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         state    <= IDLE;
         status   <= 1'b0;
         updated  <= 1'b0;
         addr_err <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) begin
            shadow[i] <= '0;
            active[i] <= '0;
         end
      end else begin
         updated <= 1'b0;
         if (write && addr_ok)
            shadow[addr] <= data_in;
         case (state)
            IDLE: begin
               if (commit) begin
                  state  <= ARMED;
                  status <= 1'b1;
               end
            end
            ARMED: begin
               // Non-blocking copy takes the pre-write shadow on a same-edge write.
               if (frame_start) begin
                  for (int i = 0; i < NUM_REGS; i++)
                     active[i] <= shadow[i];
                  state    <= IDLE;
                  status   <= 1'b0;
                  updated  <= 1'b1;
                  addr_err <= 1'b0;
               end
            end
            default: begin
               state  <= IDLE;
               status <= 1'b0;
            end
         endcase
         // Placed after the copy clear so a same-edge bad write keeps the flag set.
         if (write && !addr_ok)
            addr_err <= 1'b1;
      end
   end

   for (genvar i = 0; i < NUM_REGS; i++) begin : g_pack
      assign regs_active[i*DATA_W +: DATA_W] = active[i];
   end

`ifdef DISP_REG_WATCHDOG_EN
   localparam int CNT_W = $clog2(TIMEOUT_FRAMES + 1);

   logic [CNT_W-1:0] frame_cnt;

   always_ff @(posedge Clk) begin
      if (!Reset_n)
         frame_cnt <= '0;
      else if (copy)
         frame_cnt <= '0;
      else if (frame_start && (frame_cnt != CNT_W'(TIMEOUT_FRAMES)))
         frame_cnt <= frame_cnt + 1'b1;
   end

   assign stale = (frame_cnt == CNT_W'(TIMEOUT_FRAMES));
`else
   assign stale = 1'b0;
`endif

endmodule

// File: tb/tb_display_reg_bank.sv
// Bench for display_reg_bank: directed literal checks followed by random traffic
// checked every cycle against a transaction-level model of the bank.
module tb_display_reg_bank;
   localparam int DW = 8;
   localparam int NR = 6;
   localparam int TO = 4;
   localparam int AW = 3;

   logic              Clk = 1'b0;
   logic              Reset_n;
   logic [AW-1:0]     addr;
   logic [DW-1:0]     data_in;
   logic              write, commit, frame_start;
   logic [NR*DW-1:0]  regs_active;
   logic              status, updated, addr_err, stale;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   // Behavioural model state
   logic [DW-1:0] m_sh  [NR];
   logic [DW-1:0] m_act [NR];
   bit  m_pending, m_upd, m_err;
   int  m_frames;

   display_reg_bank #(.DATA_W(DW), .NUM_REGS(NR), .TIMEOUT_FRAMES(TO)) dut (
      .Clk(Clk), .Reset_n(Reset_n), .addr(addr), .data_in(data_in),
      .write(write), .commit(commit), .frame_start(frame_start),
      .regs_active(regs_active), .status(status), .updated(updated),
      .addr_err(addr_err), .stale(stale)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
      end
   endtask

   function automatic logic [DW-1:0] reg_of(input int i);
      return regs_active[i*DW +: DW];
   endfunction

   function automatic logic [NR*DW-1:0] model_bank();
      logic [NR*DW-1:0] v;
      for (int i = 0; i < NR; i++) v[i*DW +: DW] = m_act[i];
      return v;
   endfunction

   function automatic bit model_stale();
`ifdef DISP_REG_WATCHDOG_EN
      return m_frames == TO;
`else
      return 1'b0;
`endif
   endfunction

   // Model: one transaction per rising edge, evaluated from the spec rules.
   always @(posedge Clk) begin
      logic [DW-1:0] nsh [NR];
      bit do_copy, bad_wr;
      if (!Reset_n) begin
         for (int i = 0; i < NR; i++) begin m_sh[i] = '0; m_act[i] = '0; end
         m_pending = 0; m_upd = 0; m_err = 0; m_frames = 0;
      end else begin
         nsh = m_sh;
         bad_wr = 0;
         if (write) begin
            if (int'(addr) < NR) nsh[addr] = data_in;
            else bad_wr = 1;
         end
         do_copy = m_pending && frame_start;
         m_upd = do_copy;
         if (do_copy) begin
            m_act = m_sh;
            m_pending = 0;
            m_err = 0;
            m_frames = 0;
         end else begin
            if (commit) m_pending = 1;
            if (frame_start && m_frames < TO) m_frames++;
         end
         if (bad_wr) m_err = 1;
         m_sh = nsh;
      end
   end

   always @(negedge Clk) begin
      if (chk_en) begin
         chk("bank",     regs_active, model_bank());
         chk("status",   status,      m_pending);
         chk("updated",  updated,     m_upd);
         chk("addr_err", addr_err,    m_err);
         chk("stale",    stale,       model_stale());
      end
   end

   task automatic cyc(input logic rn, input logic w, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic c, input logic f);
      Reset_n = rn; write = w; addr = a; data_in = d; commit = c; frame_start = f;
      @(posedge Clk);
      @(negedge Clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0);
   endtask

   initial begin
      Reset_n = 0; write = 0; addr = 0; data_in = 0; commit = 0; frame_start = 0;
      @(negedge Clk);
      cyc(0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0);
      chk_en = 1'b1;
      chk("rst_bank",   regs_active, '0);
      chk("rst_status", status, 1'b0);
      chk("rst_err",    addr_err, 1'b0);

      // Shadow write does not reach the active bank
      cyc(1, 1, 2, 8'hA5, 0, 0);
      chk("t1_reg2", reg_of(2), 8'h00);
      chk("t1_status", status, 1'b0);

      // Commit, frame_start three cycles later
      cyc(1, 0, 0, 0, 1, 0);
      chk("t2_status_armed", status, 1'b1);
      idle(2);
      chk("t2_reg2_wait", reg_of(2), 8'h00);
      cyc(1, 0, 0, 0, 0, 1);
      chk("t2_reg2", reg_of(2), 8'hA5);
      chk("t2_upd", updated, 1'b1);
      chk("t2_status_done", status, 1'b0);
      idle(1);
      chk("t2_upd_off", updated, 1'b0);

      // Write on the copying frame_start edge misses that copy
      cyc(1, 0, 0, 0, 1, 0);
      cyc(1, 1, 1, 8'h3C, 0, 1);
      chk("t3_reg1_old", reg_of(1), 8'h00);
      chk("t3_reg2_keep", reg_of(2), 8'hA5);
      cyc(1, 0, 0, 0, 1, 0);
      cyc(1, 0, 0, 0, 0, 1);
      chk("t3_reg1_new", reg_of(1), 8'h3C);

      // Out-of-range write
      cyc(1, 1, 7, 8'hFF, 0, 0);
      chk("t4_err", addr_err, 1'b1);
      chk("t4_bank", regs_active, 48'h0000_0000_A53C_00 << 0);
      cyc(1, 0, 0, 0, 1, 0);
      cyc(1, 0, 0, 0, 0, 1);
      chk("t4_err_clr", addr_err, 1'b0);

      // Commit with frame_start from IDLE: copy deferred
      cyc(1, 1, 0, 8'h77, 0, 0);
      cyc(1, 0, 0, 0, 1, 1);
      chk("t5_status", status, 1'b1);
      chk("t5_no_upd", updated, 1'b0);
      chk("t5_reg0_old", reg_of(0), 8'h00);
      idle(1);
      cyc(1, 0, 0, 0, 0, 1);
      chk("t5_upd", updated, 1'b1);
      chk("t5_reg0_new", reg_of(0), 8'h77);

      // Watchdog and reset while armed
      for (int i = 0; i < TO - 1; i++) cyc(1, 0, 0, 0, 0, 1);
      chk("t6_not_stale", stale, 1'b0);
      cyc(1, 0, 0, 0, 0, 1);
`ifdef DISP_REG_WATCHDOG_EN
      chk("t6_stale", stale, 1'b1);
`else
      chk("t6_stale_off", stale, 1'b0);
`endif
      cyc(1, 0, 0, 0, 1, 0);
      cyc(1, 0, 0, 0, 0, 1);
      chk("t6_stale_clr", stale, 1'b0);
      cyc(1, 0, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 0, 0);
      chk("t6_rst_status", status, 1'b0);
      chk("t6_rst_bank", regs_active, '0);

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         cyc(($urandom_range(0, 299) != 0),
             ($urandom_range(0, 2) == 0),
             AW'($urandom_range(0, 7)),
             DW'($urandom),
             ($urandom_range(0, 5) == 0),
             ($urandom_range(0, 3) == 0));
      end

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
